// File: rtl/fdtd_pingpong_buffer.sv
// Multi-channel ping-pong field buffer for the FDTD engine.
// Each channel has two banks. The "old" bank is read by compute and filled by streaming load.
// The "new" bank is written by compute and emptied by the ready/valid drain.
// A per-channel swap exchanges the roles of the two banks.
// Optional feature macro: FDTD_BUF_CLEAR_EN (adds a CLEAR state that zeroes both banks of one channel).
module fdtd_pingpong_buffer #(
  parameter int unsigned FDTD_DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_ADDR_WIDTH = 6,
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   load_start_i,
  input  logic [CH_W-1:0]                        load_ch_i,
  input  logic [BUFFER_ADDR_WIDTH:0]             load_len_i,
  input  logic                                   load_valid_i,
  input  logic [FDTD_DATA_WIDTH-1:0]             load_data_i,
  output logic                                   load_done_o,
  input  logic                                   drain_start_i,
  input  logic [CH_W-1:0]                        drain_ch_i,
  input  logic [BUFFER_ADDR_WIDTH:0]             drain_len_i,
  input  logic                                   drain_ready_i,
  output logic                                   drain_valid_o,
  output logic [FDTD_DATA_WIDTH-1:0]             drain_data_o,
  output logic                                   drain_last_o,
  output logic                                   drain_done_o,
`ifdef FDTD_BUF_CLEAR_EN
  input  logic                                   clear_i,
  input  logic [CH_W-1:0]                        clear_ch_i,
`endif
  input  logic [NUM_CH-1:0]                      old_rd_en_i,
  input  logic [NUM_CH*BUFFER_ADDR_WIDTH-1:0]    old_rd_addr_i,
  output logic [NUM_CH*FDTD_DATA_WIDTH-1:0]      old_rd_data_o,
  input  logic [NUM_CH-1:0]                      new_wr_en_i,
  input  logic [NUM_CH*BUFFER_ADDR_WIDTH-1:0]    new_wr_addr_i,
  input  logic [NUM_CH*FDTD_DATA_WIDTH-1:0]      new_wr_data_i,
  input  logic [NUM_CH-1:0]                      swap_i,
  output logic [NUM_CH-1:0]                      bank_sel_o,
  output logic                                   busy_o,
  output logic                                   err_o
);

  localparam int unsigned DW    = FDTD_DATA_WIDTH;
  localparam int unsigned AW    = BUFFER_ADDR_WIDTH;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);

`ifdef FDTD_BUF_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StClear} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;
`endif

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     addr_q, addr_d;   // load write addr / drain read addr / clear addr
  logic [LW-1:0]     acc_q, acc_d;     // drain words accepted
  logic              err_q, err_d;
  logic              load_done_q, load_done_d;
  logic [NUM_CH-1:0] bank_sel_q, bank_sel_d;

  logic [DW-1:0]     mem_q [NUM_CH][2][DEPTH];
  logic [NUM_CH*DW-1:0] old_rd_data_q;

  logic [DW-1:0]     skid_q [2];
  logic [1:0]        cnt_q;
  logic              rd_ptr_q, wr_ptr_q;

  logic              load_we, drain_push, drain_pop, drain_fin, start_any;
`ifdef FDTD_BUF_CLEAR_EN
  logic              clr_we;
`endif

  function automatic logic len_ok(input logic [LW-1:0] len);
    return (len != '0) && (len <= DepthL);
  endfunction

  // Next-state logic for the shared transfer FSM, error flag and bank selects.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    len_d       = len_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    err_d       = err_q;
    bank_sel_d  = bank_sel_q;
    load_done_d = 1'b0;
    load_we     = 1'b0;
    drain_push  = 1'b0;
`ifdef FDTD_BUF_CLEAR_EN
    clr_we      = 1'b0;
    start_any   = load_start_i | drain_start_i | clear_i;
`else
    start_any   = load_start_i | drain_start_i;
`endif
    drain_pop   = (cnt_q != 2'd0) && drain_ready_i;
    drain_fin   = drain_pop && (acc_q == len_q - LW'(1));

    if (state_q != StIdle && start_any) err_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (load_start_i) begin
          if (drain_start_i) err_d = 1'b1;
          if (len_ok(load_len_i)) begin
            state_d = StLoad;
            ch_d    = load_ch_i;
            len_d   = load_len_i;
            addr_d  = '0;
          end else begin
            err_d = 1'b1;
          end
`ifdef FDTD_BUF_CLEAR_EN
        end else if (clear_i) begin
          state_d = StClear;
          ch_d    = clear_ch_i;
          addr_d  = '0;
`endif
        end else if (drain_start_i) begin
          if (len_ok(drain_len_i)) begin
            state_d = StDrain;
            ch_d    = drain_ch_i;
            len_d   = drain_len_i;
            addr_d  = '0;
            acc_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (load_valid_i) begin
          load_we = 1'b1;
          addr_d  = addr_q + LW'(1);
          if (addr_q == len_q - LW'(1)) begin
            state_d     = StIdle;
            load_done_d = 1'b1;
          end
        end
      end
      StDrain: begin
        // The RAM read lands in the skid at the issuing edge, so nothing is left in flight
        // across an edge and occupancy alone bounds the issue.
        if ((addr_q < len_q) && (cnt_q < 2'd2)) begin
          drain_push = 1'b1;
          addr_d     = addr_q + LW'(1);
        end
        if (drain_pop) acc_d = acc_q + LW'(1);
        if (drain_fin) state_d = StIdle;
      end
`ifdef FDTD_BUF_CLEAR_EN
      StClear: begin
        clr_we = 1'b1;
        addr_d = addr_q + LW'(1);
        if (addr_q == DepthL - LW'(1)) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // A channel owned by the active transfer may not flip banks under it.
    for (int c = 0; c < NUM_CH; c++) begin
      if (swap_i[c]) begin
        if (state_q != StIdle && ch_q == CH_W'(c)) err_d = 1'b1;
        else bank_sel_d[c] = !bank_sel_q[c];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      load_done_q <= 1'b0;
      bank_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      load_done_q <= load_done_d;
      bank_sel_q  <= bank_sel_d;
    end
  end

  // Bank storage: compute writes hit the new bank, load writes hit the old bank.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef FDTD_BUF_CLEAR_EN
      if (clr_we && ch_q == CH_W'(c)) begin
        mem_q[c][0][addr_q[AW-1:0]] <= '0;
        mem_q[c][1][addr_q[AW-1:0]] <= '0;
      end else begin
`else
      begin
`endif
        if (new_wr_en_i[c]) begin
          mem_q[c][!bank_sel_q[c]][new_wr_addr_i[c*AW +: AW]] <= new_wr_data_i[c*DW +: DW];
        end
        if (load_we && ch_q == CH_W'(c)) begin
          mem_q[c][bank_sel_q[c]][addr_q[AW-1:0]] <= load_data_i;
        end
      end
    end
  end

  // Compute reads of the old bank; pre-edge bank_sel gives the pre-swap bank.
  always_ff @(posedge CLK) begin
    if (RST) begin
      old_rd_data_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (old_rd_en_i[c]) begin
          old_rd_data_q[c*DW +: DW] <= mem_q[c][bank_sel_q[c]][old_rd_addr_i[c*AW +: AW]];
        end
      end
    end
  end

  // Two-entry drain skid; head entry stays put while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      cnt_q     <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
    end else if (drain_fin) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (drain_push) begin
        skid_q[wr_ptr_q] <= mem_q[ch_q][!bank_sel_q[ch_q]][addr_q[AW-1:0]];
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (drain_pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, drain_push} - {1'b0, drain_pop};
    end
  end

  assign load_done_o   = load_done_q;
  assign drain_valid_o = (cnt_q != 2'd0);
  assign drain_data_o  = skid_q[rd_ptr_q];
  assign drain_last_o  = drain_valid_o && (acc_q == len_q - LW'(1));
  assign drain_done_o  = drain_fin;
  assign old_rd_data_o = old_rd_data_q;
  assign bank_sel_o    = bank_sel_q;
  assign busy_o        = (state_q != StIdle);
  assign err_o         = err_q;

endmodule

// File: tb/tb_fdtd_pingpong_buffer.sv
// Self-checking bench for fdtd_pingpong_buffer with a bank-level reference model.
module tb_fdtd_pingpong_buffer;
  localparam int DW = 32, AW = 6, NCH = 2, CHW = 1, LW = 7, DEPTH = 64;

  logic CLK = 1'b0;
  logic RST;
  logic load_start_i, load_valid_i, load_done_o;
  logic [CHW-1:0] load_ch_i, drain_ch_i;
  logic [LW-1:0] load_len_i, drain_len_i;
  logic [DW-1:0] load_data_i, drain_data_o;
  logic drain_start_i, drain_ready_i, drain_valid_o, drain_last_o, drain_done_o;
  logic [NCH-1:0] old_rd_en_i, new_wr_en_i, swap_i, bank_sel_o;
  logic [NCH*AW-1:0] old_rd_addr_i, new_wr_addr_i;
  logic [NCH*DW-1:0] old_rd_data_o, new_wr_data_i;
  logic busy_o, err_o;

  fdtd_pingpong_buffer dut (
    .CLK(CLK), .RST(RST),
    .load_start_i(load_start_i), .load_ch_i(load_ch_i), .load_len_i(load_len_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_done_o(load_done_o),
    .drain_start_i(drain_start_i), .drain_ch_i(drain_ch_i), .drain_len_i(drain_len_i),
    .drain_ready_i(drain_ready_i), .drain_valid_o(drain_valid_o), .drain_data_o(drain_data_o),
    .drain_last_o(drain_last_o), .drain_done_o(drain_done_o),
    .old_rd_en_i(old_rd_en_i), .old_rd_addr_i(old_rd_addr_i), .old_rd_data_o(old_rd_data_o),
    .new_wr_en_i(new_wr_en_i), .new_wr_addr_i(new_wr_addr_i), .new_wr_data_i(new_wr_data_i),
    .swap_i(swap_i), .bank_sel_o(bank_sel_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words per channel per bank, and which bank is "old".
  logic [DW-1:0] m_mem [NCH][2][DEPTH];
  logic [NCH-1:0] m_sel;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    m_sel = '0;
  endtask

  task automatic cwrite(input int ch, input int a, input logic [DW-1:0] d);
    new_wr_en_i = '0;
    new_wr_en_i[ch] = 1'b1;
    new_wr_addr_i[ch*AW +: AW] = AW'(a);
    new_wr_data_i[ch*DW +: DW] = d;
    tick();
    new_wr_en_i = '0;
    m_mem[ch][!m_sel[ch]][a] = d;
  endtask

  task automatic rd_old(input int ch, input int a, output logic [DW-1:0] d);
    old_rd_en_i = '0;
    old_rd_en_i[ch] = 1'b1;
    old_rd_addr_i[ch*AW +: AW] = AW'(a);
    tick();
    old_rd_en_i = '0;
    d = old_rd_data_o[ch*DW +: DW];
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err_o); end
    n_vec++; if (bank_sel_o !== '0) begin n_err++; $display("FAIL reset_bank_sel got %b exp 0", bank_sel_o); end
    n_vec++; if (drain_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", drain_valid_o); end
    n_vec++; if (load_done_o !== 1'b0) begin n_err++; $display("FAIL reset_load_done got %b exp 0", load_done_o); end
    n_vec++; if (old_rd_data_o !== '0) begin n_err++; $display("FAIL reset_old_rd got %h exp 0", old_rd_data_o); end
  endtask

  task automatic test_load(input int ch, input int len, input logic rnd);
    int i, cyc, dones;
    logic [DW-1:0] d;
    load_ch_i = CHW'(ch);
    load_len_i = LW'(len);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL load_busy got %b exp 1", busy_o); end
    i = 0; cyc = 0; dones = 0;
    while (i < len && cyc < 1000) begin
      load_valid_i = 1'($urandom_range(0, 1));
      d = rnd ? DW'($urandom) : DW'(32'h10 + i);
      load_data_i = d;
      tick();
      if (load_valid_i) begin
        m_mem[ch][m_sel[ch]][i] = d;
        i++;
      end
      if (load_done_o === 1'b1) dones++;
      cyc++;
    end
    load_valid_i = 1'b0;
    tick();
    if (load_done_o === 1'b1) dones++;
    n_vec++; if (i != len) begin n_err++; $display("FAIL load_timeout got %0d exp %0d", i, len); end
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL load_done_count got %0d exp 1", dones); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL load_idle got %b exp 0", busy_o); end
    for (int a = 0; a < len; a++) begin
      rd_old(ch, a, d);
      n_vec++;
      if (d !== m_mem[ch][m_sel[ch]][a]) begin
        n_err++; $display("FAIL load_readback ch%0d addr%0d got %h exp %h", ch, a, d, m_mem[ch][m_sel[ch]][a]);
      end
    end
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic test_drain(input int ch, input int len, input int mode);
    int got, k, first_k, dones;
    logic stall;
    logic [DW-1:0] held, exp_d;
    got = 0; k = 0; first_k = -1; dones = 0; stall = 1'b0; held = '0;
    drain_ch_i = CHW'(ch);
    drain_len_i = LW'(len);
    drain_start_i = 1'b1;
    tick();
    drain_start_i = 1'b0;
    while (got < len && k < 2000) begin
      case (mode)
        0: drain_ready_i = 1'b1;
        1: drain_ready_i = ((k % 4) == 0) || ((k % 4) == 3);
        default: drain_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stall) begin
        n_vec++;
        if (drain_valid_o !== 1'b1 || drain_data_o !== held) begin
          n_err++; $display("FAIL drain_hold got v=%b d=%h exp v=1 d=%h", drain_valid_o, drain_data_o, held);
        end
      end
      if (drain_valid_o === 1'b1) begin
        if (first_k < 0) first_k = k;
        exp_d = m_mem[ch][!m_sel[ch]][got];
        n_vec++;
        if (drain_last_o !== (got == len - 1)) begin
          n_err++; $display("FAIL drain_last idx%0d got %b exp %b", got, drain_last_o, (got == len - 1));
        end
        if (drain_ready_i) begin
          n_vec++;
          if (drain_data_o !== exp_d) begin
            n_err++; $display("FAIL drain_data ch%0d idx%0d got %h exp %h", ch, got, drain_data_o, exp_d);
          end
          if (drain_done_o === 1'b1) dones++;
          got++;
        end
        stall = !drain_ready_i;
        held = drain_data_o;
      end else begin
        stall = 1'b0;
      end
      tick();
      k++;
    end
    drain_ready_i = 1'b0;
    n_vec++; if (got != len) begin n_err++; $display("FAIL drain_count got %0d exp %0d", got, len); end
    n_vec++; if (first_k != 1) begin n_err++; $display("FAIL drain_latency got %0d exp 1", first_k); end
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL drain_done_count got %0d exp 1", dones); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL drain_idle got %b exp 0", busy_o); end
    n_vec++; if (drain_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b exp 0", drain_valid_o); end
  endtask

  task automatic test_drain_full();
    for (int a = 0; a < DEPTH; a++) cwrite(1, a, DW'(a + 32'h100));
    test_drain(1, 64, 0);
  endtask

  task automatic test_drain_stall();
    for (int a = 0; a < 8; a++) cwrite(0, a, DW'($urandom));
    test_drain(0, 8, 1);
  endtask

  task automatic test_drain_random();
    int ch;
    ch = $urandom_range(0, 1);
    for (int a = 0; a < DEPTH; a++) cwrite(ch, a, DW'($urandom));
    test_drain(ch, $urandom_range(1, 64), 2);
  endtask

  task automatic test_swap();
    logic [DW-1:0] d, pre;
    int cyc;
    test_load(0, 8, 1'b1);
    cwrite(0, 5, 32'hABCD);
    pre = m_mem[0][m_sel[0]][5];
    swap_i = 2'b01;
    old_rd_en_i = 2'b01;
    old_rd_addr_i[0 +: AW] = AW'(5);
    tick();
    swap_i = '0;
    old_rd_en_i = '0;
    m_sel[0] = !m_sel[0];
    n_vec++; if (old_rd_data_o[0 +: DW] !== pre) begin n_err++; $display("FAIL swap_cycle_read got %h exp %h", old_rd_data_o[0 +: DW], pre); end
    n_vec++; if (bank_sel_o !== m_sel) begin n_err++; $display("FAIL swap_bank_sel got %b exp %b", bank_sel_o, m_sel); end
    rd_old(0, 5, d);
    n_vec++; if (d !== 32'hABCD) begin n_err++; $display("FAIL swap_read got %h exp abcd", d); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL swap_err_clean got %b exp 0", err_o); end
    // swap of the channel under drain must be refused
    drain_ch_i = 1'b0;
    drain_len_i = LW'(4);
    drain_start_i = 1'b1;
    tick();
    drain_start_i = 1'b0;
    swap_i = 2'b01;
    tick();
    swap_i = '0;
    n_vec++; if (bank_sel_o !== m_sel) begin n_err++; $display("FAIL swap_busy_bank_sel got %b exp %b", bank_sel_o, m_sel); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL swap_busy_err got %b exp 1", err_o); end
    drain_ready_i = 1'b1;
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 50) begin tick(); cyc++; end
    drain_ready_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL swap_drain_finish got %b exp 0", busy_o); end
  endtask

  task automatic test_errors();
    logic [DW-1:0] d;
    do_reset();
    load_ch_i = 1'b1; load_len_i = LW'(4);
    drain_ch_i = 1'b0; drain_len_i = LW'(4);
    load_start_i = 1'b1; drain_start_i = 1'b1;
    tick();
    load_start_i = 1'b0; drain_start_i = 1'b0;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL both_start_busy got %b exp 1", busy_o); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL both_start_err got %b exp 1", err_o); end
    for (int i = 0; i < 4; i++) begin
      load_valid_i = 1'b1;
      load_data_i = DW'($urandom);
      m_mem[1][m_sel[1]][i] = load_data_i;
      tick();
    end
    load_valid_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL both_start_load_end got %b exp 0", busy_o); end
    rd_old(1, 2, d);
    n_vec++; if (d !== m_mem[1][m_sel[1]][2]) begin n_err++; $display("FAIL both_start_load_data got %h exp %h", d, m_mem[1][m_sel[1]][2]); end

    do_reset();
    drain_len_i = '0; drain_start_i = 1'b1;
    tick();
    drain_start_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL len0_busy got %b exp 0", busy_o); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL len0_err got %b exp 1", err_o); end

    do_reset();
    load_len_i = LW'(65); load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL len65_busy got %b exp 0", busy_o); end
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL len65_err got %b exp 1", err_o); end

    do_reset();
    load_ch_i = 1'b0; load_len_i = LW'(2); load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    drain_len_i = LW'(2); drain_start_i = 1'b1;
    tick();
    drain_start_i = 1'b0;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL busy_start_err got %b exp 1", err_o); end
    for (int i = 0; i < 2; i++) begin
      load_valid_i = 1'b1;
      load_data_i = DW'($urandom);
      m_mem[0][m_sel[0]][i] = load_data_i;
      tick();
    end
    load_valid_i = 1'b0;
    tick();
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored got %b exp 0", busy_o); end
  endtask

  task automatic test_reset_mid_drain();
    int got, k;
    do_reset();
    swap_i = 2'b01;
    tick();
    swap_i = '0;
    m_sel[0] = 1'b1;
    for (int a = 0; a < 8; a++) cwrite(1, a, DW'($urandom));
    drain_ch_i = 1'b1; drain_len_i = LW'(8); drain_start_i = 1'b1;
    tick();
    drain_start_i = 1'b0;
    drain_ready_i = 1'b1;
    got = 0; k = 0;
    while (got < 3 && k < 20) begin
      if (drain_valid_o === 1'b1) got++;
      tick();
      k++;
    end
    n_vec++; if (drain_data_o !== m_mem[1][1][3]) begin n_err++; $display("FAIL mid_word3 got %h exp %h", drain_data_o, m_mem[1][1][3]); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drain_ready_i = 1'b0;
    m_sel = '0;
    n_vec++; if (drain_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", drain_valid_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b exp 0", busy_o); end
    n_vec++; if (bank_sel_o !== '0) begin n_err++; $display("FAIL mid_rst_bank_sel got %b exp 0", bank_sel_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_err got %b exp 0", err_o); end
    n_vec++; if (drain_done_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_done got %b exp 0", drain_done_o); end
    test_drain(1, 8, 0);
  endtask

  initial begin
    RST = 1'b0;
    load_start_i = 1'b0; load_ch_i = '0; load_len_i = '0; load_valid_i = 1'b0; load_data_i = '0;
    drain_start_i = 1'b0; drain_ch_i = '0; drain_len_i = '0; drain_ready_i = 1'b0;
    old_rd_en_i = '0; old_rd_addr_i = '0; new_wr_en_i = '0; new_wr_addr_i = '0; new_wr_data_i = '0;
    swap_i = '0;
    m_sel = '0;
    test_reset();
    test_load(0, 4, 1'b0);
    test_load(1, $urandom_range(1, 64), 1'b1);
    test_drain_full();
    test_drain_stall();
    test_drain_random();
    test_drain_random();
    test_swap();
    test_errors();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
